// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Req0,
    input  logic             Req1,
    input  logic [2:0]       Op0,
    input  logic [2:0]       Op1,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic [1:0]       Grant,
    output logic [1:0]       Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero_Flag,
    output logic             Err,
    output logic             Busy,
    output logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic             ALU_Zero
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state, state_nx;
    logic             last_grant, last_grant_nx;
    logic             err_op, err_op_nx;
    logic [1:0]       grant_nx, done_nx;
    logic [WIDTH-1:0] result_nx, a_nx, b_nx;
    logic             zero_nx, err_nx;
    logic [2:0]       ctl_nx;
    logic             win, win_ok;
    logic [2:0]       win_op;

    // last_grant doubles as the identity of the op in flight
    assign win    = (Req0 & Req1) ? (FAIR ? ~last_grant : 1'b0) : Req1;
    assign win_op = win ? Op1 : Op0;
    assign win_ok = (win_op == 3'd0) || (win_op == 3'd1) || (win_op == 3'd2) ||
                    (win_op == 3'd6) || (win_op == 3'd7);

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        err_op_nx     = err_op;
        grant_nx      = 2'b00;
        done_nx       = 2'b00;
        result_nx     = Result;
        zero_nx       = Zero_Flag;
        err_nx        = 1'b0;
        ctl_nx        = ALUControl;
        a_nx          = ALU_A;
        b_nx          = ALU_B;
        case (state)
            IDLE: begin
                ctl_nx = 3'd0;
                a_nx   = '0;
                b_nx   = '0;
                if (Req0 | Req1) begin
                    state_nx      = EXEC;
                    last_grant_nx = win;
                    err_op_nx     = ~win_ok;
                    grant_nx      = win ? 2'b10 : 2'b01;
                    ctl_nx        = win_ok ? win_op : 3'd0;
                    a_nx          = win ? A1 : A0;
                    b_nx          = win ? B1 : B0;
                end
            end
            EXEC: begin
                state_nx  = DONE;
                result_nx = err_op ? '0 : ALU_Result;
                zero_nx   = err_op | ALU_Zero;
                done_nx   = last_grant ? 2'b10 : 2'b01;
                err_nx    = err_op;
            end
            DONE: begin
                state_nx = IDLE;
                ctl_nx   = 3'd0;
                a_nx     = '0;
                b_nx     = '0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            err_op     <= 1'b0;
            Grant      <= 2'b00;
            Done       <= 2'b00;
            Result     <= '0;
            Zero_Flag  <= 1'b0;
            Err        <= 1'b0;
            Busy       <= 1'b0;
            ALUControl <= 3'd0;
            ALU_A      <= '0;
            ALU_B      <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            err_op     <= err_op_nx;
            Grant      <= grant_nx;
            Done       <= done_nx;
            Result     <= result_nx;
            Zero_Flag  <= zero_nx;
            Err        <= err_nx;
            Busy       <= (state_nx != IDLE);
            ALUControl <= ctl_nx;
            ALU_A      <= a_nx;
            ALU_B      <= b_nx;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, corner sequences and randomized ops against a behavioural model
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        Req0, Req1;
    logic [2:0]  Op0, Op1;
    logic [31:0] A0, B0, A1, B1;
    logic [1:0]  Grant, Done, fp_grant, fp_done;
    logic [31:0] Result, fp_result;
    logic        Zero_Flag, Err, Busy, fp_zero, fp_err, fp_busy;
    logic [2:0]  ALUControl, fp_ctl;
    logic [31:0] ALU_A, ALU_B, ALU_Result, fp_a, fp_b, fp_alu_res;
    logic        ALU_Zero, fp_alu_zero;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic        tb_last;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign ALU_Result  = alu_fn(ALUControl, ALU_A, ALU_B);
    assign ALU_Zero    = (ALU_Result == 32'd0);
    assign fp_alu_res  = alu_fn(fp_ctl, fp_a, fp_b);
    assign fp_alu_zero = (fp_alu_res == 32'd0);

    alu_arbiter #(.WIDTH(32), .FAIR(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1), .Grant(Grant), .Done(Done), .Result(Result),
        .Zero_Flag(Zero_Flag), .Err(Err), .Busy(Busy), .ALUControl(ALUControl),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Result(ALU_Result), .ALU_Zero(ALU_Zero));

    alu_arbiter #(.WIDTH(32), .FAIR(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n), .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1), .Grant(fp_grant), .Done(fp_done), .Result(fp_result),
        .Zero_Flag(fp_zero), .Err(fp_err), .Busy(fp_busy), .ALUControl(fp_ctl),
        .ALU_A(fp_a), .ALU_B(fp_b), .ALU_Result(fp_alu_res), .ALU_Zero(fp_alu_zero));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        r0, r1;
        logic [2:0]  o0, o1;
        logic [31:0] a0, b0, a1, b1;
        logic        w;
        logic [31:0] res;
        logic        z, e;
    } vec_t;

    function automatic vec_t mk(input logic r0, r1, input logic [2:0] o0, o1,
                                input logic [31:0] a0, b0, a1, b1,
                                input logic w, input logic [31:0] res, input logic z, e);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.o0 = o0; v.o1 = o1;
        v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
        v.w = w; v.res = res; v.z = z; v.e = e;
        return v;
    endfunction

    // Called just after a clock edge with the DUT idle; leaves it idle again.
    task automatic run_op(input vec_t v, input string tag);
        logic [2:0] exp_ctl;
        logic       fpw;
        exp_ctl = v.e ? 3'd0 : (v.w ? v.o1 : v.o0);
        fpw     = (v.r0 & v.r1) ? 1'b0 : v.r1;
        Req0 = v.r0; Req1 = v.r1; Op0 = v.o0; Op1 = v.o1;
        A0 = v.a0; B0 = v.b0; A1 = v.a1; B1 = v.b1;
        @(posedge clk); #1;
        chk({tag, ".grant"}, Grant, v.w ? 2'b10 : 2'b01);
        chk({tag, ".fp_grant"}, fp_grant, fpw ? 2'b10 : 2'b01);
        chk({tag, ".busy_exec"}, {Busy, Done}, 3'b100);
        chk({tag, ".aluctl"}, ALUControl, exp_ctl);
        Req0 = 1'b0; Req1 = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".done"}, {Grant, Done}, {2'b00, v.w ? 2'b10 : 2'b01});
        chk({tag, ".result"}, Result, v.res);
        chk({tag, ".zero_err"}, {Zero_Flag, Err}, {v.z, v.e});
        @(posedge clk); #1;
        chk({tag, ".idle"}, {Busy, Done, Err}, 4'b0);
        tb_last  = v.w;
        last_res = v.res;
    endtask

    initial begin
        vec_t        vecs[7];
        vec_t        v;
        logic [1:0]  sel;
        logic [2:0]  op;
        reset_n = 1'b0;
        Req0 = 0; Req1 = 0; Op0 = 0; Op1 = 0; A0 = 0; B0 = 0; A1 = 0; B1 = 0;
        tb_last = 1'b1;

        vecs[0] = mk(1, 0, 3'd0, 3'd0, 32'h59460, 32'h59461, 0, 0, 0, 32'h59460, 0, 0);
        vecs[1] = mk(0, 1, 3'd0, 3'd2, 0, 0, 32'h59460, 32'h59461, 1, 32'h000B28C1, 0, 0);
        vecs[2] = mk(0, 1, 3'd0, 3'd6, 0, 0, 32'h59460, 32'h59461, 1, 32'hFFFFFFFF, 0, 0);
        vecs[3] = mk(0, 1, 3'd0, 3'd7, 0, 0, 32'h59460, 32'h59461, 1, 32'd1, 0, 0);
        vecs[4] = mk(0, 1, 3'd0, 3'd7, 0, 0, 32'h59461, 32'h59460, 1, 32'd0, 1, 0);
        vecs[5] = mk(1, 0, 3'd4, 3'd0, 32'hFFFF, 32'hFF, 0, 0, 0, 32'd0, 1, 1);
        vecs[6] = mk(1, 0, 3'd1, 3'd0, 32'hF0, 32'h0F, 0, 0, 0, 32'hFF, 0, 0);

        #3;
        chk("reset.ctrl", {Grant, Done, Zero_Flag, Err, Busy, ALUControl}, 10'b0);
        chk("reset.data", {Result, ALU_A}, 64'b0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Idle with no request: Result holds, everything else quiet
        @(posedge clk); @(posedge clk); #1;
        chk("idle.quiet", {Grant, Done, Busy, Err, ALUControl}, 10'b0);
        chk("idle.hold", {Result, ALU_A}, {last_res, 32'h0});

        // Operands captured at grant; later changes must not leak in
        Req0 = 1; Req1 = 0; Op0 = 3'd2; A0 = 32'd5; B0 = 32'd7;
        @(posedge clk); #1;
        A0 = 32'd100; B0 = 32'd1; Req0 = 0;
        chk("capture.grant", Grant, 2'b01);
        @(posedge clk); #1;
        chk("capture.result", {Done, Result}, {2'b01, 32'd12});
        @(posedge clk); #1;
        tb_last = 1'b0;

        // Async reset during EXEC aborts the op; last grant was 0, reset restores priority to 0
        Req0 = 1; Op0 = 3'd2; A0 = 32'd9; B0 = 32'd9;
        @(posedge clk); #1;
        chk("abort.grant", Grant, 2'b01);
        Req0 = 0;
        #2 reset_n = 1'b0;
        #1;
        chk("abort.ctrl", {Grant, Done, Zero_Flag, Err, Busy, ALUControl}, 10'b0);
        chk("abort.data", {Result, ALU_A, ALU_B}, 96'b0);
        @(posedge clk); #1;
        chk("abort.nodone", {Done, Busy}, 3'b0);
        reset_n = 1'b1;
        tb_last = 1'b1;

        // Held tie: FAIR alternates 0,1,0,1; fixed priority stays on 0
        for (int i = 0; i < 4; i++) begin
            v = mk(1, 1, 3'd2, 3'd6, 32'd10, 32'd3, 32'd10, 32'd3,
                   i[0], i[0] ? 32'd7 : 32'd13, 0, 0);
            run_op(v, $sformatf("tie%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(1, 3));
            v.r0 = sel[0]; v.r1 = sel[1];
            v.o0 = 3'($urandom_range(0, 7)); v.o1 = 3'($urandom_range(0, 7));
            v.a0 = $urandom; v.b0 = ($urandom_range(0, 3) == 0) ? v.a0 : $urandom;
            v.a1 = $urandom; v.b1 = ($urandom_range(0, 3) == 0) ? v.a1 : $urandom;
            v.w  = (v.r0 & v.r1) ? ~tb_last : v.r1;
            op   = v.w ? v.o1 : v.o0;
            v.e  = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
            v.res = v.e ? 32'd0 : alu_fn(op, v.w ? v.a1 : v.a0, v.w ? v.b1 : v.b0);
            v.z  = (v.res == 32'd0);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
